branch_resolve_queue: RTL and testbench

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

---
 rtl/brq_pkg.sv | 15 +
 rtl/brq_fifo.sv | 63 ++++++
 rtl/branch_resolve_queue.sv | 100 ++++++++++
 tb/tb_branch_resolve_queue.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_pkg.sv
// Shared constants for the branch resolve queue: delay-slot offset, default
// PHT geometry and the 2-bit saturating counter encodings.
package brq_pkg;

    localparam int          PHT_DEPTH_DEFAULT = 6;
    localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } pht_ctr_e;

endpackage

// File: rtl/brq_fifo.sv
// Circular buffer with synchronous flush; the head entry is readable
// combinationally so the consumer can act on it in the cycle it pops.
module brq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             rd_fire;
    logic             wr_fire;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[head];
    assign rd_fire = rd_en & ~empty;
    // A full buffer still accepts a write when the head slot frees this cycle.
    assign wr_fire = wr_en & (~full | rd_fire);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr_fire) tail <= tail + PTR_W'(1);
            if (rd_fire) head <= head + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are qualified by count alone, which
    // keeps the array a plain RAM without a reset fan-out.
    always_ff @(posedge clk) begin
        if (wr_fire && !flush) mem[tail] <= wr_data;
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// Tracks in-flight predicted branches from F to M, detects mispredictions at
// resolve, produces recovery PC/GHR and a registered PHT update command.
module branch_resolve_queue
    import brq_pkg::*;
#(
    parameter int PHT_DEPTH = PHT_DEPTH_DEFAULT,
    parameter int QDEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    input  logic [31:0]          push_pc,
    input  logic                 push_pred_take,
    input  logic [PHT_DEPTH-1:0] push_ghr,
    input  logic                 resolve_valid,
    input  logic                 resolve_take,
    input  logic [31:0]          resolve_target,
    input  logic                 flush_all,
    output logic                 full,
    output logic                 empty,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc,
    output logic [PHT_DEPTH-1:0] restore_ghr,
    output logic                 upd_valid,
    output logic [PHT_DEPTH-1:0] upd_index,
    output logic                 upd_take,
    output logic                 overflow_err,
    output logic                 underflow_err
);

    localparam int ENTRY_W = 32 + 1 + PHT_DEPTH;

    logic [ENTRY_W-1:0]   head_entry;
    logic [31:0]          head_pc;
    logic                 head_pred;
    logic [PHT_DEPTH-1:0] head_ghr;
    logic                 pop;
    logic                 kill;
    logic                 push_ok;
    logic                 overflow_now;
    logic                 underflow_now;

    assign {head_pc, head_pred, head_ghr} = head_entry;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pop           = 1'b0;
        mispredict    = 1'b0;
        kill          = 1'b0;
        push_ok       = 1'b0;
        overflow_now  = 1'b0;
        underflow_now = 1'b0;
        redirect_pc   = head_pc + DELAY_SLOT_OFFSET;
        restore_ghr   = {head_ghr[PHT_DEPTH-2:0], resolve_take};

        pop           = resolve_valid & ~empty;
        underflow_now = resolve_valid & empty;
        mispredict    = pop & (head_pred != resolve_take);
        // A mispredict discards the wrong-path tail along with the popped head.
        kill          = mispredict | flush_all;
        push_ok       = push_valid & ~kill;
        overflow_now  = push_ok & full & ~pop;
        if (resolve_take) redirect_pc = resolve_target;
    end

    brq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_data ({push_pc, push_pred_take, push_ghr}),
        .rd_en   (pop),
        .flush   (kill),
        .rd_data (head_entry),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid     <= 1'b0;
            upd_index     <= '0;
            upd_take      <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            upd_valid <= pop;
            if (pop) begin
                upd_index <= head_pc[PHT_DEPTH+1:2] ^ head_ghr;
                upd_take  <= resolve_take;
            end
            if (overflow_now)  overflow_err  <= 1'b1;
            if (underflow_now) underflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with hand-computed expectations.
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [31:0] push_pc;
    logic        push_pred_take;
    logic [5:0]  push_ghr;
    logic        resolve_valid;
    logic        resolve_take;
    logic [31:0] resolve_target;
    logic        flush_all;
    logic        full;
    logic        empty;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [5:0]  restore_ghr;
    logic        upd_valid;
    logic [5:0]  upd_index;
    logic        upd_take;
    logic        overflow_err;
    logic        underflow_err;

    int tests  = 0;
    int failed = 0;

    branch_resolve_queue dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid     (push_valid),
        .push_pc        (push_pc),
        .push_pred_take (push_pred_take),
        .push_ghr       (push_ghr),
        .resolve_valid  (resolve_valid),
        .resolve_take   (resolve_take),
        .resolve_target (resolve_target),
        .flush_all      (flush_all),
        .full           (full),
        .empty          (empty),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .restore_ghr    (restore_ghr),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_take       (upd_take),
        .overflow_err   (overflow_err),
        .underflow_err  (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid     = 1'b0;
        push_pc        = '0;
        push_pred_take = 1'b0;
        push_ghr       = '0;
        resolve_valid  = 1'b0;
        resolve_take   = 1'b0;
        resolve_target = '0;
        flush_all      = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic pred, input logic [5:0] ghr);
        push_valid     = 1'b1;
        push_pc        = pc;
        push_pred_take = pred;
        push_ghr       = ghr;
        tick();
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check("rst_empty_during", empty, 1);
        check("rst_full_during", full, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_empty", empty, 1);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_index", upd_index, 0);
        check("rst_overflow", overflow_err, 0);
        check("rst_underflow", underflow_err, 0);

        // Correct taken prediction: index = 0x10[7:2]=0x04 ^ 0x2A = 0x2E
        push(32'h0040_0010, 1'b1, 6'h2A);
        check("t1_not_empty", empty, 0);
        resolve_valid = 1'b1;
        resolve_take  = 1'b1;
        resolve_target = 32'h0040_0500;
        #1;
        check("t1_mispredict", mispredict, 0);
        tick();
        idle();
        check("t1_upd_valid", upd_valid, 1);
        check("t1_upd_index", upd_index, 6'h2E);
        check("t1_upd_take", upd_take, 1);
        check("t1_empty", empty, 1);
        tick();
        check("t1_upd_valid_drop", upd_valid, 0);

        // Predicted not-taken, actually taken: redirect to target, ghr {10101,1}
        push(32'h0040_0020, 1'b0, 6'h15);
        resolve_valid  = 1'b1;
        resolve_take   = 1'b1;
        resolve_target = 32'h0040_0100;
        #1;
        check("t2_mispredict", mispredict, 1);
        check("t2_redirect", redirect_pc, 32'h0040_0100);
        check("t2_restore_ghr", restore_ghr, 6'h2B);
        tick();
        idle();
        check("t2_upd_valid", upd_valid, 1);
        check("t2_upd_index", upd_index, 6'h1D);
        check("t2_empty", empty, 1);

        // Predicted taken, actually not-taken: redirect to pc + 8
        push(32'h0040_0020, 1'b1, 6'h3F);
        resolve_valid  = 1'b1;
        resolve_take   = 1'b0;
        resolve_target = 32'h0040_0900;
        #1;
        check("t3_mispredict", mispredict, 1);
        check("t3_redirect", redirect_pc, 32'h0040_0028);
        check("t3_restore_ghr", restore_ghr, 6'h3E);
        tick();
        idle();
        check("t3_upd_index", upd_index, 6'h37);
        check("t3_upd_take", upd_take, 0);

        // Mispredict with 3 queued and a coincident push: everything cleared
        push(32'h0040_0100, 1'b1, 6'h01);
        push(32'h0040_0104, 1'b0, 6'h02);
        push(32'h0040_0108, 1'b1, 6'h03);
        check("t4_count3", dut.u_fifo.count, 3);
        resolve_valid  = 1'b1;
        resolve_take   = 1'b0;
        push_valid     = 1'b1;
        push_pc        = 32'h0040_010C;
        push_pred_take = 1'b1;
        #1;
        check("t4_mispredict", mispredict, 1);
        tick();
        idle();
        check("t4_count0", dut.u_fifo.count, 0);
        check("t4_empty", empty, 1);
        check("t4_upd_valid", upd_valid, 1);
        check("t4_upd_index", upd_index, 6'h01);
        check("t4_overflow", overflow_err, 0);
        tick();
        check("t4_no_wrongpath_upd1", upd_valid, 0);
        tick();
        check("t4_no_wrongpath_upd2", upd_valid, 0);

        // Fill, overflow, then push + correct resolve while full
        push(32'h0040_0200, 1'b1, 6'h00);
        push(32'h0040_0204, 1'b1, 6'h00);
        push(32'h0040_0208, 1'b1, 6'h00);
        check("t5_not_full3", full, 0);
        push(32'h0040_020C, 1'b1, 6'h00);
        check("t5_full", full, 1);
        check("t5_tail_wrap", dut.u_fifo.tail, 0);
        check("t5_overflow_pre", overflow_err, 0);
        push(32'h0040_0210, 1'b1, 6'h00);
        check("t5_overflow", overflow_err, 1);
        check("t5_count4", dut.u_fifo.count, 4);
        resolve_valid  = 1'b1;
        resolve_take   = 1'b1;
        push_valid     = 1'b1;
        push_pc        = 32'h0040_0214;
        push_pred_take = 1'b1;
        #1;
        check("t5_no_mispredict", mispredict, 0);
        tick();
        idle();
        check("t5_count_hold", dut.u_fifo.count, 4);
        check("t5_full_hold", full, 1);
        check("t5_tail_after", dut.u_fifo.tail, 1);
        check("t5_head_after", dut.u_fifo.head, 1);
        check("t5_upd_valid", upd_valid, 1);

        // flush_all with a coincident mispredicting resolve on 0x204
        flush_all     = 1'b1;
        resolve_valid = 1'b1;
        resolve_take  = 1'b0;
        #1;
        check("t6_mispredict", mispredict, 1);
        check("t6_redirect", redirect_pc, 32'h0040_020C);
        tick();
        idle();
        check("t6_empty", empty, 1);
        check("t6_upd_valid", upd_valid, 1);
        check("t6_upd_index", upd_index, 6'h01);

        // Resolve while empty
        resolve_valid = 1'b1;
        resolve_take  = 1'b1;
        #1;
        check("t7_mispredict", mispredict, 0);
        tick();
        idle();
        check("t7_underflow", underflow_err, 1);
        check("t7_upd_valid", upd_valid, 0);

        // Asynchronous reset with two entries queued
        push(32'h0040_0300, 1'b1, 6'h05);
        push(32'h0040_0304, 1'b0, 6'h06);
        check("t8_not_empty", empty, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t8_async_empty", empty, 1);
        check("t8_async_upd", upd_valid, 0);
        check("t8_async_underflow", underflow_err, 0);
        check("t8_async_overflow", overflow_err, 0);
        tick();
        rst = 1'b0;
        resolve_valid = 1'b1;
        resolve_take  = 1'b1;
        #1;
        check("t8_post_mispredict", mispredict, 0);
        tick();
        idle();
        check("t8_post_underflow", underflow_err, 1);
        check("t8_post_upd", upd_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
